// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   MUL_OP_WIDTH  width of every MULop port
//   MUL_OP_*      operation encodings understood by the shared multiplier
//   ST_*_BIT      bit positions of the one-hot controller states
package mul_share_arbiter_pkg;

  localparam int MUL_OP_WIDTH = 2;

  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MUL   = 2'd0;  // low word, any sign
  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULH  = 2'd1;  // high word, signed x signed
  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULSU = 2'd2;  // high word, signed x unsigned
  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULU  = 2'd3;  // high word, unsigned x unsigned

  localparam int ST_IDLE_BIT = 0;
  localparam int ST_BUSY_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'(1 << ST_IDLE_BIT),
    BUSY = 2'(1 << ST_BUSY_BIT)
  } state_e;

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter2.sv
// Two-way round-robin pick, purely combinational.
//   req[1:0]  requesters currently eligible
//   last      index of the requester served most recently
//   grant     index of the winner (meaningful only when req != 0)
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // On contention the requester that was not served last wins; a lone
  // requester wins regardless of history.
  assign grant = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one iterative multiplier between two requesters.
//   clk, reset                 clock, synchronous active-high reset
//   req0_*, req1_*             level requests: valid, operands, op code
//   req0_ready, req1_ready     one-cycle completion pulses
//   product                    result register, held until the next completion
//   mul_valid, mul_factor1/2,
//   mul_mulop                  request and latched operands to the multiplier
//   mul_product, mul_ready     multiplier result and completion pulse
// The multiplier itself lives one level up; its resetn is driven from
// ~reset there so both blocks abandon an operation together.
module mul_share_arbiter #(
  parameter int MUL_OP_WIDTH = mul_share_arbiter_pkg::MUL_OP_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  input  logic [31:0]             req0_factor1,
  input  logic [31:0]             req0_factor2,
  input  logic [MUL_OP_WIDTH-1:0] req0_mulop,
  input  logic                    req1_valid,
  input  logic [31:0]             req1_factor1,
  input  logic [31:0]             req1_factor2,
  input  logic [MUL_OP_WIDTH-1:0] req1_mulop,
  output logic                    req0_ready,
  output logic                    req1_ready,
  output logic [31:0]             product,
  output logic                    mul_valid,
  output logic [31:0]             mul_factor1,
  output logic [31:0]             mul_factor2,
  output logic [MUL_OP_WIDTH-1:0] mul_mulop,
  input  logic [31:0]             mul_product,
  input  logic                    mul_ready
);

  import mul_share_arbiter_pkg::*;

  state_e     state;
  logic       last_grant;
  logic       grant;
  logic       grant_q;
  logic [1:0] eligible;

  // A requester whose ready pulse is showing still holds valid for that
  // cycle; masking it stops the same transaction being issued twice.
  assign eligible = {req1_valid & ~req1_ready, req0_valid & ~req0_ready};

  rr_arbiter2 u_rr (
    .req   (eligible),
    .last  (last_grant),
    .grant (grant)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_q     <= 1'b0;
      last_grant  <= 1'b1;
      mul_valid   <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      product     <= '0;
      mul_factor1 <= '0;
      mul_factor2 <= '0;
      mul_mulop   <= '0;
    end else begin
      // Ready outputs are pulses: cleared every edge unless set below.
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;

      if (state[ST_IDLE_BIT]) begin
        // mul_ready seen here is spurious and deliberately ignored.
        if (|eligible) begin
          grant_q     <= grant;
          mul_factor1 <= grant ? req1_factor1 : req0_factor1;
          mul_factor2 <= grant ? req1_factor2 : req0_factor2;
          mul_mulop   <= grant ? req1_mulop   : req0_mulop;
          mul_valid   <= 1'b1;
          state       <= BUSY;
        end
      end else if (state[ST_BUSY_BIT]) begin
        // Operands stay frozen until mul_ready: the multiplier re-reads
        // factor1 in its last cycle for the sign fix-up.
        if (mul_ready) begin
          product    <= mul_product;
          mul_valid  <= 1'b0;
          last_grant <= grant_q;
          if (grant_q) req1_ready <= 1'b1;
          else         req0_ready <= 1'b1;
          state      <= IDLE;
        end
      end else begin
        // Not a legal one-hot code: drop any request and recover.
        mul_valid <= 1'b0;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomised and directed bench for mul_share_arbiter with a behavioural
// model of the shared multiplier and reference product arithmetic.
module tb_mul_share_arbiter;
  import mul_share_arbiter_pkg::*;

  localparam int W = MUL_OP_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rv [2];
  logic [31:0]   rf1 [2];
  logic [31:0]   rf2 [2];
  logic [W-1:0]  rop [2];
  logic          rdy0, rdy1;
  logic [31:0]   product;
  logic          mul_valid;
  logic [31:0]   mul_factor1, mul_factor2;
  logic [W-1:0]  mul_mulop;
  logic [31:0]   mul_product;
  logic          mul_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // multiplier model state
  int            lat = 34;
  bit            m_busy;
  int            m_cnt;
  logic [31:0]   cap_f1, cap_f2;
  logic [W-1:0]  cap_op;
  bit            hold_bad;
  bit            spurious_req = 1'b0;
  int            mready_cyc = 0;
  int            issue_q [$];

  // requester bookkeeping
  int            v_cyc [2];
  int            rdy_cyc [2];
  int            done_q [$];
  int            rdy_cnt [2];
  int            both_hi = 0;

  mul_share_arbiter #(.MUL_OP_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (rv[0]),
    .req0_factor1 (rf1[0]),
    .req0_factor2 (rf2[0]),
    .req0_mulop   (rop[0]),
    .req1_valid   (rv[1]),
    .req1_factor1 (rf1[1]),
    .req1_factor2 (rf2[1]),
    .req1_mulop   (rop[1]),
    .req0_ready   (rdy0),
    .req1_ready   (rdy1),
    .product      (product),
    .mul_valid    (mul_valid),
    .mul_factor1  (mul_factor1),
    .mul_factor2  (mul_factor2),
    .mul_mulop    (mul_mulop),
    .mul_product  (mul_product),
    .mul_ready    (mul_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: extend each operand per op signedness, take a
  // full 64-bit product, pick the requested word.
  function automatic logic [31:0] ref_mul(input logic [W-1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = {32'h0, a};
    xb = {32'h0, b};
    if (op == MUL_OP_MULH || op == MUL_OP_MULSU) xa = {{32{a[31]}}, a};
    if (op == MUL_OP_MULH) xb = {{32{b[31]}}, b};
    p = xa * xb;
    return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rdy0 === 1'b1) rdy_cnt[0]++;
    if (rdy1 === 1'b1) rdy_cnt[1]++;
    if (rdy0 === 1'b1 && rdy1 === 1'b1) both_hi++;
  end

  // Shared multiplier: starts on mul_valid, pulses mul_ready `lat` cycles
  // later with the product of the operands captured at start.
  initial begin
    logic rst_s, prev;
    mul_ready   = 1'b0;
    mul_product = '0;
    m_busy      = 1'b0;
    forever begin
      @(posedge clk);
      rst_s = reset;
      #1;
      prev      = mul_ready;
      mul_ready = 1'b0;
      if (prev) check("no_valid_after_mul_ready", mul_valid, 0);
      if (rst_s) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        if ({mul_factor1, mul_factor2, mul_mulop} !== {cap_f1, cap_f2, cap_op}) hold_bad = 1'b1;
        m_cnt--;
        if (m_cnt == 0) begin
          check("operand_hold", hold_bad, 0);
          mul_product = ref_mul(cap_op, cap_f1, cap_f2);
          mul_ready   = 1'b1;
          mready_cyc  = cyc;
          m_busy      = 1'b0;
        end
      end else if (mul_valid === 1'b1) begin
        m_busy   = 1'b1;
        m_cnt    = lat;
        cap_f1   = mul_factor1;
        cap_f2   = mul_factor2;
        cap_op   = mul_mulop;
        hold_bad = 1'b0;
        issue_q.push_back(cyc);
      end else if (spurious_req) begin
        mul_product  = 32'hDEAD_BEEF;
        mul_ready    = 1'b1;
        spurious_req = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge showing the ready pulse.
  task automatic do_req(input int n, input logic [W-1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    bit seen;
    exp = ref_mul(op, a, b);
    rf1[n] = a;
    rf2[n] = b;
    rop[n] = op;
    rv[n]  = 1'b1;
    v_cyc[n] = cyc;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((n == 0 ? rdy0 : rdy1) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check($sformatf("req%0d_ready_seen", n), seen, 1);
    if (seen) begin
      check($sformatf("req%0d_product", n), product, exp);
      rdy_cyc[n] = cyc;
      done_q.push_back(n);
    end
    rv[n] = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, {rdy0, rdy1, mul_valid}, 0);
    check({tag, "_product"}, product, 0);
    check({tag, "_mul_ops"}, {mul_factor1, mul_factor2, mul_mulop}, 0);
  endtask

  initial begin
    int n0, saved;
    logic [31:0] exp_p;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rf1[i] = '0; rf2[i] = '0; rop[i] = '0;
      rdy_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;

    // Single request straight out of reset, 34-cycle multiplier.
    issue_q.delete(); done_q.delete();
    do_req(0, MUL_OP_MULU, 32'h7, 32'h6);
    check("single_issue_latency", (issue_q.size() == 1) ? issue_q[0] - v_cyc[0] : -1, 1);
    check("single_ready_latency", rdy_cyc[0] - mready_cyc, 1);

    // Simultaneous requests after reset: req0 first, req1 right after.
    pulse_reset();
    issue_q.delete(); done_q.delete();
    fork
      do_req(0, MUL_OP_MUL, 32'd3, 32'd5);
      do_req(1, MUL_OP_MUL, 32'hFFFF_FFFF, 32'd2);
    join
    check("simul_order", (done_q.size() == 2) ? {done_q[0][1:0], done_q[1][1:0]} : 4'hF, 4'b0001);
    check("simul_back_to_back", (issue_q.size() == 2) ? issue_q[1] - rdy_cyc[0] : -1, 1);

    // Fairness with both requesters always requesting.
    lat = 3;
    pulse_reset();
    done_q.delete();
    fork
      for (int i = 0; i < 5; i++) do_req(0, W'($urandom_range(0, 3)), $urandom, $urandom);
      for (int i = 0; i < 5; i++) do_req(1, W'($urandom_range(0, 3)), $urandom, $urandom);
    join
    check("fair_count", done_q.size(), 10);
    n0 = 0;
    foreach (done_q[i]) begin
      check($sformatf("fair_grant_%0d", i), done_q[i], i % 2);
      if (done_q[i] == 0) n0++;
    end
    check("fair_req0_share", n0, 5);

    // Operand hold while the idle requester's operands churn.
    lat = 34;
    fork
      do_req(1, MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        rf1[0] = $urandom;
        rf2[0] = $urandom;
        rop[0] = W'($urandom_range(0, 3));
      end
    join
    check("hold_product_value", product, 32'h4000_0000);

    // Reset ten cycles into BUSY abandons the operation.
    rf1[1] = 32'h1234_5678; rf2[1] = 32'h9; rop[1] = MUL_OP_MUL; rv[1] = 1'b1;
    for (int i = 0; i < 20 && mul_valid !== 1'b1; i++) @(negedge clk);
    check("midop_busy", mul_valid, 1);
    repeat (10) @(negedge clk);
    saved = rdy_cnt[0] + rdy_cnt[1];
    reset = 1'b1;
    rv[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midop_reset");
    repeat (40) @(negedge clk);
    check("midop_no_ready", rdy_cnt[0] + rdy_cnt[1], saved);
    do_req(1, MUL_OP_MULSU, 32'hFFFF_FFFF, 32'd3);

    // Spurious mul_ready while idle.
    exp_p = ref_mul(MUL_OP_MULSU, 32'hFFFF_FFFF, 32'd3);
    saved = rdy_cnt[0] + rdy_cnt[1];
    spurious_req = 1'b1;
    repeat (4) @(negedge clk);
    check("spurious_product", product, exp_p);
    check("spurious_no_ready", rdy_cnt[0] + rdy_cnt[1], saved);
    check("spurious_no_valid", mul_valid, 0);
    do_req(0, MUL_OP_MUL, 32'd9, 32'd9);

    // Random traffic with short multiplier latencies and idle gaps.
    lat = $urandom_range(1, 6);
    done_q.delete();
    fork
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_req(0, W'($urandom_range(0, 3)), $urandom, $urandom);
      end
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_req(1, W'($urandom_range(0, 3)), $urandom, $urandom);
      end
    join
    check("random_completions", done_q.size(), 30);
    check("ready_exclusive", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 The block SHALL take parameter MUL_OP_WIDTH, default `MUL_OP_WIDTH from riscv_defines.vh, giving the width of all MULop ports.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  — sole clock; all state updates on rising edge.
REQ-004 reset  input  1  — synchronous, active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  — level request; held until the matching ready pulse.
REQ-006 req0_factor1/req0_factor2, req1_factor1/req1_factor2  input  32 each  — operands; stable while the matching valid is high.
REQ-007 req0_mulop, req1_mulop  input  MUL_OP_WIDTH each  — operation code: MUL, MULH, MULSU or MULU.
REQ-008 req0_ready, req1_ready  output  1 each  — one-cycle completion pulse.
REQ-009 product  output  32  — result register; valid in the ready-pulse cycle; held until the next completion.
REQ-010 mul_valid  output  1  — request to the shared multiplier.
REQ-011 mul_factor1, mul_factor2  output  32 each  — latched operands for the multiplier.
REQ-012 mul_mulop  output  MUL_OP_WIDTH  — latched op for the multiplier.
REQ-013 mul_product  input  32  — multiplier result.
REQ-014 mul_ready  input  1  — one-cycle multiplier completion pulse.

Function
REQ-015 The state machine SHALL be one-hot with states IDLE and BUSY.
REQ-016 A requester SHALL be eligible in IDLE only when reqN_valid=1 and reqN_ready=0 in the same cycle.
REQ-017 In IDLE, when any requester is eligible, the block SHALL grant exactly one requester and latch its factor1, factor2 and mulop into mul_*.
  - In the same edge it SHALL set mul_valid=1 and move to BUSY.
REQ-018 Arbitration SHALL be round-robin on register last_grant.
  - Both eligible: the requester other than last_grant wins.
  - One eligible: it wins regardless of last_grant.
REQ-019 mul_factor1, mul_factor2 and mul_mulop SHALL stay constant from issue until mul_ready is sampled, because the multiplier re-reads factor1 for sign fix-up in its final cycle.
REQ-020 In BUSY, on mul_ready=1 the block SHALL, in one edge:
  - capture mul_product into product;
  - set mul_valid=0;
  - pulse req<grant>_ready=1 for exactly one cycle;
  - set last_grant=grant;
  - return to IDLE.
REQ-021 In BUSY without mul_ready, the block SHALL hold all outputs.
  - It SHALL ignore the other requester; that request stays pending and no latency limit applies.
REQ-022 Latency SHALL be:
  - IDLE to issue: 1 cycle.
  - mul_ready to reqN_ready: 1 cycle.
  - Back-to-back: a pending other requester SHALL be issued in the cycle after the ready pulse (its IDLE cycle), with no extra bubble.
REQ-023 The block SHALL never assert mul_valid in the cycle where mul_ready=1, nor in the cycle immediately after, so the multiplier's !ready guard is never relied on.
REQ-024 mul_ready received in IDLE (spurious) SHALL be ignored, and product SHALL be unchanged.
REQ-025 req0_ready and req1_ready SHALL never be high in the same cycle.
REQ-026 Operand changes on a non-granted requester SHALL have no effect on mul_* outputs.

Reset
REQ-027 On reset=1 at a clock edge the block SHALL enter IDLE with:
  - mul_valid=0, req0_ready=0, req1_ready=0;
  - product=0, mul_factor1=0, mul_factor2=0, mul_mulop=0;
  - last_grant=1, so req0 wins the first simultaneous request.
REQ-028 Reset in BUSY SHALL abandon the operation with no ready pulse.
  - The top level SHALL drive the multiplier's resetn from ~reset so both blocks reset together.
REQ-029 The first eligible request after reset deasserts SHALL be issued one cycle later.

Structure
REQ-030 MUL_OP_* encodings and MUL_OP_WIDTH SHALL come from the shared riscv_defines.vh; state bit indices SHALL be local parameters.
REQ-031 The round-robin pick SHALL be a separate combinational sub-module rr_arbiter2 with inputs req[1:0] and last, and output grant.
REQ-032 The shared multiplier SHALL be instantiated outside this block, one level up.

Verification
REQ-033 Single request: req0 MULU 0x0000_0007 × 0x0000_0006, multiplier model 34-cycle latency -> mul_valid one cycle after req0_valid; req0_ready pulse one cycle after mul_ready; product=0x0000_0000 (high word).
REQ-034 Simultaneous requests after reset: req0 MUL 3×5, req1 MUL 0xFFFF_FFFF×2 -> req0 served first (product 0x0000_000F), then req1 issued the very next IDLE cycle (product 0xFFFF_FFFE).
REQ-035 Fairness: both requesters continuously re-request for 10 transactions -> grants alternate 0,1,0,1…; each requester completes exactly 5.
REQ-036 Operand hold: req1 MULH 0x8000_0000×0x8000_0000; toggle req0 operands every cycle during BUSY -> mul_factor1/mul_factor2 constant throughout; product=0x4000_0000.
REQ-037 Reset mid-op: assert reset for 1 cycle 10 cycles into BUSY -> no ready pulse; all outputs zero; a fresh req1 request is then served with the correct product.
REQ-038 Spurious mul_ready in IDLE -> no state change, no ready pulse, product unchanged.
